// File: rtl/hashcrack_pkg.sv
// Shared types and constants for the hash-cracking datapath: hash width, dispatcher
// state encodings, hashchecker handshake timing and saturating counter helpers.
package hashcrack_pkg;

  localparam int HASH_W = 128;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT_HI = 2'd2,
    ST_WAIT_LO = 2'd3
  } disp_state_e;

  // hashchecker raises resultrdy this many cycles after checkrdy, and holds it high this long
  localparam int CHK_RESULT_DLY_MIN = 4;
  localparam int CHK_RESULT_DLY_MAX = 5;
  localparam int CHK_RESULT_HI_CYC  = 2;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/check_dispatcher_if.sv
// Bundle of upstream entry, hashchecker handshake, match report and status signals
// around check_dispatcher; slave is the dispatcher side, master the environment side.
interface check_dispatcher_if import hashcrack_pkg::*; #(
  parameter int CAND_W = 48
);
  logic              in_valid;
  logic              in_ready;
  logic [HASH_W-1:0] in_hash;
  logic [CAND_W-1:0] in_cand;
  logic              chk_checkrdy;
  logic [HASH_W-1:0] chk_hash;
  logic              chk_resultrdy;
  logic              chk_matchfound;
  logic              match_valid;
  logic [CAND_W-1:0] match_cand;
  logic              match_ack;
  logic [31:0]       checked_count;
  logic [15:0]       match_count;
  logic              busy;
  logic              error;

  modport slave (
    input  in_valid, in_hash, in_cand, chk_resultrdy, chk_matchfound, match_ack,
    output in_ready, chk_checkrdy, chk_hash, match_valid, match_cand,
           checked_count, match_count, busy, error
  );

  modport master (
    output in_valid, in_hash, in_cand, chk_resultrdy, chk_matchfound, match_ack,
    input  in_ready, chk_checkrdy, chk_hash, match_valid, match_cand,
           checked_count, match_count, busy, error
  );
endinterface

// File: rtl/hash_fifo.sv
// Registered synchronous FIFO holding {hash, candidate} entries; head is visible on dout.
module hash_fifo #(
  parameter int WIDTH = 176,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             push_ok_s, pop_ok_s;

  // Extra pointer bit distinguishes full from empty when the indices coincide
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty = (wr_q == rd_q);
  assign dout  = mem_q[rd_q[AW-1:0]];

  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;

  always_comb begin
    mem_d = mem_q;
    if (push_ok_s) begin
      mem_d[wr_q[AW-1:0]] = din;
    end else begin
      mem_d = mem_q;
    end
    wr_d = push_ok_s ? wr_q + (AW+1)'(1) : wr_q;
    rd_d = pop_ok_s  ? rd_q + (AW+1)'(1) : rd_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/check_dispatcher.sv
// Buffers (hash, candidate) pairs, runs one checkrdy/resultrdy transaction per entry
// against hashchecker, and holds a matching candidate until the host acknowledges it.
module check_dispatcher import hashcrack_pkg::*; #(
  parameter int DEPTH   = 4,
  parameter int CAND_W  = 48,
  parameter int TIMEOUT = 32
) (
  input logic               clk,
  input logic               rst_n,
  check_dispatcher_if.slave bus
);
  localparam int ENTRY_W = HASH_W + CAND_W;
  localparam int WCNT_W  = $clog2(TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT - 1);

  disp_state_e       state_q, state_d;
  logic [HASH_W-1:0] hash_q, hash_d;
  logic [CAND_W-1:0] cand_q, cand_d;
  logic              checkrdy_q, checkrdy_d;
  logic              match_lat_q, match_lat_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              match_valid_q, match_valid_d;
  logic [CAND_W-1:0] match_cand_q, match_cand_d;
  logic [31:0]       checked_count_q, checked_count_d;
  logic [15:0]       match_count_q, match_count_d;
  logic              error_q, error_d;

  logic               push_s, pop_s, fifo_full_s, fifo_empty_s;
  logic [ENTRY_W-1:0] fifo_head_s;

  assign push_s = bus.in_valid && !fifo_full_s;

  hash_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .din   ({bus.in_hash, bus.in_cand}),
    .pop   (pop_s),
    .dout  (fifo_head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  always_comb begin
    state_d         = state_q;
    hash_d          = hash_q;
    cand_d          = cand_q;
    checkrdy_d      = 1'b0;
    match_lat_d     = match_lat_q;
    wcnt_d          = wcnt_q;
    match_cand_d    = match_cand_q;
    checked_count_d = checked_count_q;
    match_count_d   = match_count_q;
    error_d         = error_q;
    pop_s           = 1'b0;
    // An ack is overridden below when a new match completes in the same cycle
    if (match_valid_q && bus.match_ack) begin
      match_valid_d = 1'b0;
    end else begin
      match_valid_d = match_valid_q;
    end
    case (state_q)
      ST_IDLE: begin
        // A high resultrdy here is stale (hashchecker survives our reset), so wait it out
        if (!fifo_empty_s && !match_valid_q && !bus.chk_resultrdy && !error_q) begin
          pop_s      = 1'b1;
          hash_d     = fifo_head_s[ENTRY_W-1:CAND_W];
          cand_d     = fifo_head_s[CAND_W-1:0];
          checkrdy_d = 1'b1;
          state_d    = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        wcnt_d  = '0;
        state_d = ST_WAIT_HI;
      end
      ST_WAIT_HI: begin
        if (bus.chk_resultrdy) begin
          match_lat_d = bus.chk_matchfound;
          wcnt_d      = '0;
          state_d     = ST_WAIT_LO;
        end else if (wcnt_q == WCNT_LAST) begin
          error_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
      end
      ST_WAIT_LO: begin
        if (!bus.chk_resultrdy) begin
          checked_count_d = sat_inc32(checked_count_q);
          if (match_lat_q) begin
            match_valid_d = 1'b1;
            match_cand_d  = cand_q;
            match_count_d = sat_inc16(match_count_q);
          end else begin
            match_count_d = match_count_q;
          end
          state_d = ST_IDLE;
        end else if (wcnt_q == WCNT_LAST) begin
          error_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      hash_q          <= '0;
      cand_q          <= '0;
      checkrdy_q      <= 1'b0;
      match_lat_q     <= 1'b0;
      wcnt_q          <= '0;
      match_valid_q   <= 1'b0;
      match_cand_q    <= '0;
      checked_count_q <= 32'd0;
      match_count_q   <= 16'd0;
      error_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      hash_q          <= hash_d;
      cand_q          <= cand_d;
      checkrdy_q      <= checkrdy_d;
      match_lat_q     <= match_lat_d;
      wcnt_q          <= wcnt_d;
      match_valid_q   <= match_valid_d;
      match_cand_q    <= match_cand_d;
      checked_count_q <= checked_count_d;
      match_count_q   <= match_count_d;
      error_q         <= error_d;
    end
  end

  assign bus.in_ready      = !fifo_full_s;
  assign bus.chk_checkrdy  = checkrdy_q;
  assign bus.chk_hash      = hash_q;
  assign bus.match_valid   = match_valid_q;
  assign bus.match_cand    = match_cand_q;
  assign bus.checked_count = checked_count_q;
  assign bus.match_count   = match_count_q;
  assign bus.busy          = !fifo_empty_s || (state_q != ST_IDLE);
  assign bus.error         = error_q;

endmodule

// File: tb/tb_check_dispatcher.sv
// Directed bench for check_dispatcher with a behavioural hashchecker and an entry scoreboard.
module tb_check_dispatcher;
  import hashcrack_pkg::*;

  localparam int DEPTH   = 4;
  localparam int CAND_W  = 48;
  localparam int TIMEOUT = 32;
  localparam logic [127:0] H0 = 128'h31D6CFE0D16AE931B73C59D7E0C089C0;

  typedef struct {
    logic [127:0]      h;
    logic [CAND_W-1:0] c;
    bit                m;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   n_chk = 0;
  int   chk_cyc = 0;
  int   push_cyc = 0;
  int   chk_base = 0;
  int   rst_gen = 0;
  bit   model_en = 1'b1;
  ent_t exp_q[$];
  logic [CAND_W-1:0] rep_q[$];

  check_dispatcher_if #(.CAND_W(CAND_W)) bus ();

  check_dispatcher #(.DEPTH(DEPTH), .CAND_W(CAND_W), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Cycle counter and checkrdy pulse counter (samples the pre-edge value)
  always @(posedge clk) begin
    if (bus.chk_checkrdy) begin
      n_chk   <= n_chk + 1;
      chk_cyc <= cyc;
    end
    cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Behavioural hashchecker: scores each issued hash against the scoreboard head
  initial begin
    bus.chk_resultrdy  = 1'b0;
    bus.chk_matchfound = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.chk_checkrdy && model_en) begin
        ent_t e;
        int   d;
        int   g;
        g = rst_gen;
        chk("sb_nonempty", 128'(exp_q.size() > 0), 128'd1);
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = '{128'd0, '0, 1'b0};
        chk("issue_hash", bus.chk_hash, e.h);
        d = $urandom_range(CHK_RESULT_DLY_MAX, CHK_RESULT_DLY_MIN);
        for (int i = 0; i < d; i++) begin
          @(negedge clk);
          if (g == rst_gen) begin
            if (i == 0) chk("checkrdy_one_cycle", bus.chk_checkrdy, 1'b0);
            chk("hash_stable_wait", bus.chk_hash, e.h);
          end
        end
        bus.chk_resultrdy  = 1'b1;
        bus.chk_matchfound = e.m;
        for (int i = 0; i < CHK_RESULT_HI_CYC; i++) begin
          @(negedge clk);
          if (g == rst_gen) chk("hash_stable_hi", bus.chk_hash, e.h);
        end
        bus.chk_resultrdy  = 1'b0;
        bus.chk_matchfound = 1'b0;
        if (e.m && g == rst_gen) rep_q.push_back(e.c);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic bit cond(input int sel);
    case (sel)
      0:       return !bus.busy;
      1:       return bus.match_valid;
      2:       return bus.error;
      3:       return bus.chk_resultrdy;
      4:       return !bus.chk_resultrdy;
      5:       return n_chk > chk_base;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input string tag, input int sel, input int maxc);
    bit ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (cond(sel)) begin
        ok = 1'b1;
        break;
      end
    end
    chk(tag, 128'(ok), 128'd1);
  endtask

  // Leaves in_valid high; caller deasserts it after the last back-to-back push
  task automatic push(input logic [127:0] h, input logic [CAND_W-1:0] c, input bit m,
                      input bit scored);
    bit acc = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_hash  = h;
    bus.in_cand  = c;
    for (int i = 0; i < 200 && !acc; i++) begin
      acc = bus.in_ready;
      if (acc) push_cyc = cyc;
      @(posedge clk);
      @(negedge clk);
    end
    chk("push_accept", 128'(acc), 128'd1);
    if (acc && scored) exp_q.push_back('{h, c, m});
  endtask

  task automatic ack();
    bus.match_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.match_ack = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rst_gen++;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_in_ready"}, bus.in_ready, 1'b1);
    chk({tag, "_checkrdy"}, bus.chk_checkrdy, 1'b0);
    chk({tag, "_chk_hash"}, bus.chk_hash, 128'd0);
    chk({tag, "_match_valid"}, bus.match_valid, 1'b0);
    chk({tag, "_match_cand"}, bus.match_cand, 48'd0);
    chk({tag, "_checked"}, bus.checked_count, 32'd0);
    chk({tag, "_mcount"}, bus.match_count, 16'd0);
    chk({tag, "_busy"}, bus.busy, 1'b0);
    chk({tag, "_error"}, bus.error, 1'b0);
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_hash    = '0;
    bus.in_cand    = '0;
    bus.match_ack  = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // Single entry, no match
    push(H0, 48'd5, 1'b0, 1'b1);
    bus.in_valid = 1'b0;
    wait_for("t1_done", 0, 60);
    chk("t1_latency", 128'(chk_cyc - push_cyc), 128'd2);
    chk("t1_nchk", 128'(n_chk), 128'd1);
    chk("t1_checked", bus.checked_count, 32'd1);
    chk("t1_match_valid", bus.match_valid, 1'b0);

    // Single entry, match
    push(H0, 48'd5, 1'b1, 1'b1);
    bus.in_valid = 1'b0;
    wait_for("t2_match", 1, 60);
    chk("t2_rep_avail", 128'(rep_q.size()), 128'd1);
    if (rep_q.size() > 0) chk("t2_cand_sb", bus.match_cand, rep_q.pop_front());
    chk("t2_cand", bus.match_cand, 48'd5);
    chk("t2_mcount", bus.match_count, 16'd1);
    chk("t2_checked", bus.checked_count, 32'd2);

    // Burst of six while the previous report is still pending
    for (int i = 0; i < 4; i++) push(H0 ^ 128'(i + 1), 48'(16 + i), 1'b0, 1'b1);
    bus.in_valid = 1'b0;
    chk("t3_full", bus.in_ready, 1'b0);
    chk("t3_stalled", bus.match_valid, 1'b1);
    ack();
    chk("t2_ack_clears", bus.match_valid, 1'b0);
    for (int i = 4; i < 6; i++) push(H0 ^ 128'(i + 1), 48'(16 + i), 1'b0, 1'b1);
    bus.in_valid = 1'b0;
    wait_for("t3_done", 0, 300);
    chk("t3_checked", bus.checked_count, 32'd8);
    chk("t3_nchk", 128'(n_chk), 128'd8);
    chk("t3_mcount", bus.match_count, 16'd1);
    chk("t3_sb_empty", 128'(exp_q.size()), 128'd0);

    // Two consecutive matches without ack
    push(H0 ^ 128'h100, 48'h100, 1'b0, 1'b1);
    push(H0 ^ 128'h200, 48'h200, 1'b1, 1'b1);
    push(H0 ^ 128'h300, 48'h300, 1'b1, 1'b1);
    bus.in_valid = 1'b0;
    wait_for("t4_first", 1, 120);
    if (rep_q.size() > 0) chk("t4_cand1_sb", bus.match_cand, rep_q.pop_front());
    chk("t4_cand1", bus.match_cand, 48'h200);
    chk_base = n_chk;
    repeat (20) @(negedge clk);
    chk("t4_stall_nchk", 128'(n_chk), 128'(chk_base));
    chk("t4_still_valid", bus.match_valid, 1'b1);
    chk("t4_cand_held", bus.match_cand, 48'h200);
    chk("t4_busy", bus.busy, 1'b1);
    ack();
    wait_for("t4_second", 1, 60);
    if (rep_q.size() > 0) chk("t4_cand2_sb", bus.match_cand, rep_q.pop_front());
    chk("t4_cand2", bus.match_cand, 48'h300);
    chk("t4_mcount", bus.match_count, 16'd3);
    ack();
    wait_for("t4_done", 0, 60);
    chk("t4_checked", bus.checked_count, 32'd11);
    chk("t4_cleared", bus.match_valid, 1'b0);

    // hashchecker never answers
    do_reset();
    model_en = 1'b0;
    chk_base = n_chk;
    push(H0, 48'd1, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    wait_for("t5_issue", 5, 20);
    repeat (15) @(negedge clk);
    chk("t5_no_early_err", bus.error, 1'b0);
    wait_for("t5_error", 2, TIMEOUT + 10);
    chk("t5_checked", bus.checked_count, 32'd0);
    chk("t5_mcount", bus.match_count, 16'd0);
    chk("t5_idle", bus.busy, 1'b0);
    push(H0, 48'd2, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    repeat (40) @(negedge clk);
    chk("t5_no_dispatch", 128'(n_chk), 128'(chk_base + 1));
    chk("t5_sticky", bus.error, 1'b1);
    chk("t5_queued", bus.busy, 1'b1);

    // Reset during WAIT_HI, stale resultrdy after release
    do_reset();
    model_en = 1'b1;
    chk_base = n_chk;
    push(H0 ^ 128'h7, 48'd7, 1'b0, 1'b1);
    bus.in_valid = 1'b0;
    wait_for("t6_issue", 5, 20);
    rst_n = 1'b0;
    rst_gen++;
    wait_for("t6_stale_hi", 3, 12);
    rst_n = 1'b1;
    check_reset_vals("t6");
    push(H0 ^ 128'h9, 48'd9, 1'b0, 1'b1);
    bus.in_valid = 1'b0;
    chk_base = n_chk;
    wait_for("t6_stale_lo", 4, 10);
    chk("t6_no_issue_on_stale", 128'(n_chk), 128'(chk_base));
    wait_for("t6_done", 0, 60);
    chk("t6_checked", bus.checked_count, 32'd1);
    chk("t6_error", bus.error, 1'b0);
    chk("t6_match_valid", bus.match_valid, 1'b0);
    chk("t6_sb_empty", 128'(exp_q.size()), 128'd0);
    chk("t6_rep_empty", 128'(rep_q.size()), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
